puf_crp_sequencer: RTL and testbench

- Controller between the 32-bit UART receiver, the arbiter PUF and the 32-bit UART transmitter.
- Takes a received challenge word, gray-codes it and drives it into the PUF.
- Runs NUM_EVALS timed evaluations with enable/rest windows and majority-votes each response bit.
- Hands the voted response to the transmitter with a start/done handshake. Replaces the free-running delay-line enable with an explicit state machine.

---
 rtl/puf_crp_sequencer_if.sv | 37 +++
 rtl/puf_crp_sequencer.sv | 174 +++++++++++++++++
 tb/tb_puf_crp_sequencer.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/puf_crp_sequencer_if.sv
// Bundles the sequencer's receive, PUF and transmit signals.
//   master : environment side (UART receiver, PUF, UART transmitter, debug host)
//   slave  : the sequencer itself
// Signals:
//   rx_valid/rx_data/loopback  received word and mode, sampled together
//   clr_err                    synchronous clear of the overrun flag
//   puf_en/puf_challenge       PUF enable and registered challenge
//   puf_response               PUF response, valid after the settle window
//   tx_start/tx_data/tx_done   transmit handshake
//   busy/overrun/state         status and debug
interface puf_crp_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             rx_valid;
  logic [WIDTH-1:0] rx_data;
  logic             loopback;
  logic             clr_err;
  logic             puf_en;
  logic [WIDTH-1:0] puf_challenge;
  logic [WIDTH-1:0] puf_response;
  logic             tx_start;
  logic [WIDTH-1:0] tx_data;
  logic             tx_done;
  logic             busy;
  logic             overrun;
  logic [2:0]       state;

  modport master (
    output rx_valid, rx_data, loopback, clr_err, puf_response, tx_done,
    input  puf_en, puf_challenge, tx_start, tx_data, busy, overrun, state
  );

  modport slave (
    input  rx_valid, rx_data, loopback, clr_err, puf_response, tx_done,
    output puf_en, puf_challenge, tx_start, tx_data, busy, overrun, state
  );
endinterface

// File: rtl/puf_crp_sequencer.sv
// Challenge/response sequencer between a UART receiver, an arbiter PUF and a
// UART transmitter. A received word becomes the (optionally gray-coded) PUF
// challenge; the PUF is evaluated NUM_EVALS times with settle/rest windows and
// each response bit is majority-voted before being handed to the transmitter.
// Loopback mode echoes the received word without touching the PUF.
// Ports:
//   clk   system clock, rising edge
//   rst_n asynchronous active-low reset
//   bus   puf_crp_sequencer_if.slave (rx, PUF, tx handshake, status)
module puf_crp_sequencer #(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned REST_CYCLES   = 2,
  parameter int unsigned NUM_EVALS     = 5,
  parameter bit          GRAY_EN       = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  puf_crp_sequencer_if.slave   bus
);

  localparam int unsigned CntW = $clog2(NUM_EVALS + 1);

  localparam logic [7:0]      SettleLast = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0]      RestLast   = 8'(REST_CYCLES - 1);
  localparam logic [3:0]      EvalLast   = 4'(NUM_EVALS - 1);
  localparam logic [CntW-1:0] Half       = CntW'(NUM_EVALS / 2);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StArm    = 3'd1,
    StSample = 3'd2,
    StRest   = 3'd3,
    StSend   = 3'd4,
    StWaitTx = 3'd5
  } state_e;

  state_e                     state_q, state_d;
  logic                       puf_en_q, puf_en_d;
  logic [WIDTH-1:0]           challenge_q, challenge_d;
  logic                       tx_start_q, tx_start_d;
  logic [WIDTH-1:0]           tx_data_q, tx_data_d;
  logic                       overrun_q, overrun_d;
  logic [7:0]                 tmr_q, tmr_d;
  logic [3:0]                 eval_q, eval_d;
  logic [WIDTH-1:0][CntW-1:0] ones_q, ones_d;

  // Per-bit running count including the response present this cycle; only
  // consumed in the sample state, where it can reach at most NUM_EVALS.
  logic [WIDTH-1:0][CntW-1:0] ones_sum;
  logic [WIDTH-1:0]           vote;

  always_comb begin
    ones_sum = '0;
    vote     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ones_sum[i] = ones_q[i] + CntW'(bus.puf_response[i]);
      vote[i]     = ones_sum[i] > Half;
    end
  end

  always_comb begin
    state_d     = state_q;
    puf_en_d    = puf_en_q;
    challenge_d = challenge_q;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    tmr_d       = tmr_q;
    eval_d      = eval_q;
    ones_d      = ones_q;

    // A word arriving outside idle is lost; a simultaneous drop beats clr_err.
    overrun_d = overrun_q;
    if (bus.rx_valid && (state_q != StIdle)) begin
      overrun_d = 1'b1;
    end else if (bus.clr_err) begin
      overrun_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
        if (bus.rx_valid) begin
          if (bus.loopback) begin
            tx_data_d  = bus.rx_data;
            tx_start_d = 1'b1;
            state_d    = StSend;
          end else begin
            challenge_d = GRAY_EN ? (bus.rx_data ^ (bus.rx_data >> 1)) : bus.rx_data;
            ones_d      = '0;
            eval_d      = '0;
            tmr_d       = '0;
            puf_en_d    = 1'b1;
            state_d     = StArm;
          end
        end
      end
      StArm: begin
        if (tmr_q == SettleLast) begin
          tmr_d   = '0;
          state_d = StSample;
        end else begin
          tmr_d = tmr_q + 8'd1;
        end
      end
      StSample: begin
        ones_d   = ones_sum;
        eval_d   = eval_q + 4'd1;
        puf_en_d = 1'b0;
        if (eval_q == EvalLast) begin
          tx_data_d  = vote;
          tx_start_d = 1'b1;
          state_d    = StSend;
        end else begin
          state_d = StRest;
        end
      end
      StRest: begin
        if (tmr_q == RestLast) begin
          tmr_d    = '0;
          puf_en_d = 1'b1;
          state_d  = StArm;
        end else begin
          tmr_d = tmr_q + 8'd1;
        end
      end
      StSend: begin
        state_d = StWaitTx;
      end
      StWaitTx: begin
        if (bus.tx_done) begin
          state_d = StIdle;
        end
      end
      default: begin
        // Unused encodings fall back to idle with the PUF disabled.
        puf_en_d = 1'b0;
        state_d  = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      puf_en_q    <= 1'b0;
      challenge_q <= '0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      overrun_q   <= 1'b0;
      tmr_q       <= '0;
      eval_q      <= '0;
      ones_q      <= '0;
    end else begin
      state_q     <= state_d;
      puf_en_q    <= puf_en_d;
      challenge_q <= challenge_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      overrun_q   <= overrun_d;
      tmr_q       <= tmr_d;
      eval_q      <= eval_d;
      ones_q      <= ones_d;
    end
  end

  assign bus.puf_en        = puf_en_q;
  assign bus.puf_challenge = challenge_q;
  assign bus.tx_start      = tx_start_q;
  assign bus.tx_data       = tx_data_q;
  assign bus.overrun       = overrun_q;
  assign bus.busy          = (state_q != StIdle);
  assign bus.state         = state_q;

endmodule

// File: tb/tb_puf_crp_sequencer.sv
// Bench for puf_crp_sequencer: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a timeline model.
module tb_puf_crp_sequencer;

  localparam int unsigned W    = 32;
  localparam int unsigned S    = 4;
  localparam int unsigned R    = 2;
  localparam int unsigned N    = 3;
  localparam int unsigned P    = S + 1 + R;
  localparam int unsigned LPUF = N * (S + 1) + (N - 1) * R + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  puf_crp_sequencer_if #(.WIDTH(W)) bus ();

  puf_crp_sequencer #(
    .WIDTH        (W),
    .SETTLE_CYCLES(S),
    .REST_CYCLES  (R),
    .NUM_EVALS    (N),
    .GRAY_EN      (1'b1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Timeline model: after a word is accepted, cycle j (1-based) of the job has
  // outputs fixed by arithmetic on j; samples happen at the end of each settle
  // window, tx_start at cycle L, waiting from L+1 until tx_done.
  // ---------------------------------------------------------------------------
  bit          m_busy = 1'b0;
  bit          m_loop = 1'b0;
  int          m_j = 0;
  int          m_l = 0;
  int          m_ns = 0;
  int          m_ones[W];
  logic [31:0] m_chal = '0;
  logic [31:0] m_tx = '0;
  bit          m_ovr = 1'b0;

  initial begin
    logic        c_rst, c_rv, c_lb, c_clr, c_done;
    logic [31:0] c_data, c_resp;
    int          p;
    logic [2:0]  e_state;
    logic        e_en;
    forever begin
      @(posedge clk);
      c_rst  = rst_n;
      c_rv   = bus.rx_valid;
      c_lb   = bus.loopback;
      c_clr  = bus.clr_err;
      c_done = bus.tx_done;
      c_data = bus.rx_data;
      c_resp = bus.puf_response;
      #1;
      if (!c_rst) begin
        m_busy = 1'b0;
        m_chal = '0;
        m_tx   = '0;
        m_ovr  = 1'b0;
      end else begin
        if (m_busy && c_rv) m_ovr = 1'b1;
        else if (c_clr) m_ovr = 1'b0;
        if (m_busy) begin
          if (!m_loop && m_j < m_l && ((m_j - 1) % P) == S) begin
            for (int i = 0; i < W; i++) m_ones[i] += int'(c_resp[i]);
            m_ns++;
            if (m_ns == N) begin
              for (int i = 0; i < W; i++) m_tx[i] = (m_ones[i] > N / 2);
            end
          end
          if (m_j > m_l && c_done) m_busy = 1'b0;
          else m_j++;
        end else if (c_rv) begin
          m_busy = 1'b1;
          m_j    = 1;
          m_loop = c_lb;
          if (c_lb) begin
            m_tx = c_data;
            m_l  = 1;
          end else begin
            m_chal = c_data ^ (c_data >> 1);
            m_l    = LPUF;
            m_ns   = 0;
            for (int i = 0; i < W; i++) m_ones[i] = 0;
          end
        end
      end
      e_en    = 1'b0;
      e_state = 3'd0;
      if (m_busy) begin
        if (m_j < m_l) begin
          p       = (m_j - 1) % P;
          e_en    = !m_loop && (p <= S);
          e_state = (p < S) ? 3'd1 : (p == S) ? 3'd2 : 3'd3;
        end else begin
          e_state = (m_j == m_l) ? 3'd4 : 3'd5;
        end
      end
      chk("m_state", 32'(bus.state), 32'(e_state));
      chk("m_busy", 32'(bus.busy), 32'(m_busy));
      chk("m_puf_en", 32'(bus.puf_en), 32'(e_en));
      chk("m_tx_start", 32'(bus.tx_start), 32'(m_busy && m_j == m_l));
      chk("m_challenge", bus.puf_challenge, m_chal);
      chk("m_tx_data", bus.tx_data, m_tx);
      chk("m_overrun", 32'(bus.overrun), 32'(m_ovr));
    end
  end

  // ---------------------------------------------------------------------------
  // Directed helpers
  // ---------------------------------------------------------------------------
  function automatic logic exp_en(input int k);
    return (k >= 1 && k <= 5) || (k >= 8 && k <= 12) || (k >= 15 && k <= 19);
  endfunction

  task automatic run_puf(input logic [31:0] data, input logic [31:0] r0, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [31:0] exp_chal,
                         input logic [31:0] exp_tx, input int inj_k, input int rst_k);
    int start_k;
    start_k = -1;
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = data;
    bus.loopback = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      bus.rx_valid = (k == inj_k);
      if (k == inj_k) bus.rx_data = 32'hDEADBEEF;
      bus.tx_done      = (k == 3);  // ignored: lands in the settle window
      bus.puf_response = (k <= 7) ? r0 : (k <= 14) ? r1 : r2;
      chk("d_puf_en", 32'(bus.puf_en), 32'(exp_en(k)));
      chk("d_busy", 32'(bus.busy), 32'd1);
      if (k == 1) chk("d_challenge", bus.puf_challenge, exp_chal);
      if (k == inj_k + 1) chk("d_overrun_set", 32'(bus.overrun), 32'd1);
      if (k == rst_k) begin
        rst_n = 1'b0;
        #1;
        chk("r_puf_en", 32'(bus.puf_en), 32'd0);
        chk("r_challenge", bus.puf_challenge, 32'd0);
        chk("r_tx_start", 32'(bus.tx_start), 32'd0);
        chk("r_tx_data", bus.tx_data, 32'd0);
        chk("r_overrun", 32'(bus.overrun), 32'd0);
        chk("r_state", 32'(bus.state), 32'd0);
        chk("r_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (bus.tx_start && start_k < 0) start_k = k;
    end
    chk("d_tx_start_cycle", 32'(start_k), 32'd20);
    chk("d_tx_data", bus.tx_data, exp_tx);
    chk("d_challenge_hold", bus.puf_challenge, exp_chal);
    @(negedge clk);
    bus.tx_done = 1'b1;
    @(negedge clk);
    bus.tx_done = 1'b0;
    chk("d_idle_after_done", 32'(bus.state), 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int          starts;
    int          waited;
    logic [31:0] held;
    bus.rx_valid     = 1'b0;
    bus.rx_data      = '0;
    bus.loopback     = 1'b0;
    bus.clr_err      = 1'b0;
    bus.puf_response = '0;
    bus.tx_done      = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_puf_en", 32'(bus.puf_en), 32'd0);
    chk("rst_tx_data", bus.tx_data, 32'd0);
    rst_n = 1'b1;

    run_puf(32'h00000003, 32'hFFFF0000, 32'hFFFF0000, 32'h0000FFFF,
            32'h00000002, 32'hFFFF0000, -10, -10);
    run_puf(32'h0000000F, 32'hAAAAAAAA, 32'h55555555, 32'hAAAAAAAA,
            32'h00000008, 32'hAAAAAAAA, 10, -10);

    // overrun is still set from the dropped word; clr_err alone clears it
    chk("ovr_sticky", 32'(bus.overrun), 32'd1);
    @(negedge clk);
    bus.clr_err = 1'b1;
    @(negedge clk);
    bus.clr_err = 1'b0;
    chk("ovr_clear", 32'(bus.overrun), 32'd0);

    // loopback, drop-with-clear, long tx_done hold
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 32'h12345678;
    bus.loopback = 1'b1;
    @(negedge clk);
    bus.loopback = 1'b0;
    chk("lb_tx_start", 32'(bus.tx_start), 32'd1);
    chk("lb_tx_data", bus.tx_data, 32'h12345678);
    chk("lb_state", 32'(bus.state), 32'd4);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 32'h0BADF00D;
    bus.clr_err  = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    chk("ovr_set_wins", 32'(bus.overrun), 32'd1);
    @(negedge clk);
    bus.clr_err = 1'b0;
    chk("ovr_clr_alone", 32'(bus.overrun), 32'd0);
    starts = 0;
    held   = bus.tx_data;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.tx_start) starts++;
      chk("hold_tx_data", bus.tx_data, held);
    end
    chk("hold_no_restart", 32'(starts), 32'd0);
    chk("hold_state", 32'(bus.state), 32'd5);
    bus.tx_done = 1'b1;
    @(negedge clk);
    bus.tx_done = 1'b0;
    chk("lb_idle_after_done", 32'(bus.state), 32'd0);

    // reset during ARM, then a fresh run with zeroed accumulators
    run_puf(32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
            32'h00000007, 32'h0, -10, 9);
    run_puf(32'h00000001, 32'hFFFFFFFF, 32'h00000000, 32'h00000000,
            32'h00000001, 32'h00000000, -10, -10);

    // randomized traffic, checked by the model every cycle
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      bus.rx_valid     = ($urandom_range(0, 15) == 0);
      bus.rx_data      = $urandom;
      bus.loopback     = ($urandom_range(0, 3) == 0);
      bus.clr_err      = ($urandom_range(0, 31) == 0);
      bus.tx_done      = ($urandom_range(0, 9) == 0);
      bus.puf_response = $urandom;
    end

    // drain: bounded wait for the last job to finish
    bus.rx_valid = 1'b0;
    bus.clr_err  = 1'b0;
    waited = 0;
    while (bus.busy && waited < 60) begin
      @(negedge clk);
      bus.tx_done = ~bus.tx_done;
      waited++;
    end
    @(negedge clk);
    bus.tx_done = 1'b0;
    @(negedge clk);
    chk("drain_idle", 32'(bus.busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
